// File: rtl/alu_unit_pkg.sv
// ============================================================================
// Module : alu_unit_pkg
// Brief  : Shared widths, opcode encodings and queue depth for the ALU unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_unit_pkg;

    localparam int ALU_OP_WIDTH  = 4;
    localparam int ALU_XLEN      = 32;
    localparam int ALU_ID_W      = 4;
    localparam int ALU_RES_DEPTH = 2;

    // Encodings 14 and 15 are unassigned and produce a zero result.
    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SHL  = 4'd5,
        ALU_SHR  = 4'd6,
        ALU_SHRA = 4'd7,
        ALU_EQ   = 4'd8,
        ALU_NEQ  = 4'd9,
        ALU_LT   = 4'd10,
        ALU_LTU  = 4'd11,
        ALU_GE   = 4'd12,
        ALU_GEU  = 4'd13
    } alu_op_e;

endpackage

`default_nettype wire

// File: rtl/alu_unit_if.sv
// ============================================================================
// Module : alu_unit_if
// Brief  : RS->ALU issue bus plus ALU broadcast/CDB grant signals.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface alu_unit_if
    import alu_unit_pkg::*;
#(
    parameter int XLEN = ALU_XLEN,
    parameter int ID_W = ALU_ID_W
);

    logic                    rs_ready;
    logic [ALU_OP_WIDTH-1:0] rs_op;
    logic [XLEN-1:0]         rs_val1;
    logic [XLEN-1:0]         rs_val2;
    logic [ID_W-1:0]         rs_id;
    logic                    cdb_grant;
    logic                    alu_busy;
    logic                    alu_ready;
    logic [XLEN-1:0]         alu_res;
    logic [ID_W-1:0]         alu_id;
    logic                    alu_overflow;

    // Master is the RS/CDB side; slave is the ALU unit.
    modport master (
        output rs_ready, rs_op, rs_val1, rs_val2, rs_id, cdb_grant,
        input  alu_busy, alu_ready, alu_res, alu_id, alu_overflow
    );

    modport slave (
        input  rs_ready, rs_op, rs_val1, rs_val2, rs_id, cdb_grant,
        output alu_busy, alu_ready, alu_res, alu_id, alu_overflow
    );

endinterface

`default_nettype wire

// File: rtl/alu_unit_core.sv
// ============================================================================
// Module : alu_core
// Brief  : Pure combinational ALU datapath, (op, a, b) -> res.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_core
    import alu_unit_pkg::*;
#(
    parameter int XLEN = ALU_XLEN
) (
    input  wire logic [ALU_OP_WIDTH-1:0] i_op,
    input  wire logic [XLEN-1:0]         i_a,
    input  wire logic [XLEN-1:0]         i_b,
    output logic      [XLEN-1:0]         o_res
);

    localparam int c_SHW = $clog2(XLEN);

    logic [c_SHW-1:0] w_shamt;
    assign w_shamt = i_b[c_SHW-1:0];

    always_comb begin
        o_res = '0;
        case (i_op)
            ALU_ADD:  o_res = i_a + i_b;
            ALU_SUB:  o_res = i_a - i_b;
            ALU_AND:  o_res = i_a & i_b;
            ALU_OR:   o_res = i_a | i_b;
            ALU_XOR:  o_res = i_a ^ i_b;
            ALU_SHL:  o_res = i_a << w_shamt;
            ALU_SHR:  o_res = i_a >> w_shamt;
            ALU_SHRA: o_res = $signed(i_a) >>> w_shamt;
            ALU_EQ:   o_res = {{(XLEN-1){1'b0}}, i_a == i_b};
            ALU_NEQ:  o_res = {{(XLEN-1){1'b0}}, i_a != i_b};
            ALU_LT:   o_res = {{(XLEN-1){1'b0}}, $signed(i_a) <  $signed(i_b)};
            ALU_LTU:  o_res = {{(XLEN-1){1'b0}}, i_a <  i_b};
            ALU_GE:   o_res = {{(XLEN-1){1'b0}}, $signed(i_a) >= $signed(i_b)};
            ALU_GEU:  o_res = {{(XLEN-1){1'b0}}, i_a >= i_b};
            default:  o_res = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_unit.sv
// ============================================================================
// Module : alu_unit
// Brief  : ALU execution unit: computes issued ops into a small FIFO result
//          queue drained under CDB grant, with backpressure and overflow flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_unit
    import alu_unit_pkg::*;
#(
    parameter int RES_DEPTH = ALU_RES_DEPTH,
    parameter int XLEN      = ALU_XLEN,
    parameter int ID_W      = ALU_ID_W
) (
    input wire logic  clk,
    input wire logic  rst,
    input wire logic  flush,
    alu_unit_if.slave bus
);

    localparam int c_PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(RES_DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(RES_DEPTH);

    logic [XLEN-1:0]    r_res [RES_DEPTH];
    logic [ID_W-1:0]    r_id  [RES_DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_busy;
    logic               r_overflow;

    logic [XLEN-1:0]    w_core_res;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic [c_CNT_W-1:0] w_count_nxt;

    alu_core #(
        .XLEN (XLEN)
    ) u_core (
        .i_op  (bus.rs_op),
        .i_a   (bus.rs_val1),
        .i_b   (bus.rs_val2),
        .o_res (w_core_res)
    );

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL);
    assign w_pop   = !w_empty && bus.cdb_grant;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign w_push  = bus.rs_ready && (!w_full || w_pop);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_busy  <= (w_count_nxt == c_FULL);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Overflow survives a flush; only a full reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (!flush && bus.rs_ready && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    // Storage needs no reset: entries are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (!rst && !flush && w_push) begin
            r_res[r_wr_ptr] <= w_core_res;
            r_id[r_wr_ptr]  <= bus.rs_id;
        end
    end

    assign bus.alu_ready    = !w_empty;
    assign bus.alu_busy     = r_busy;
    assign bus.alu_overflow = r_overflow;
    assign bus.alu_res      = w_empty ? '0 : r_res[r_rd_ptr];
    assign bus.alu_id       = w_empty ? '0 : r_id[r_rd_ptr];

endmodule

`default_nettype wire

// File: tb/tb_alu_unit.sv
// ============================================================================
// Module : tb_alu_unit
// Brief  : Self-checking bench for alu_unit: opcode vector table through a
//          result scoreboard, plus hand sequences for queue corner cases.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_unit;
    import alu_unit_pkg::*;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  id;
    } exp_t;

    logic clk;
    logic rst;
    logic flush;
    int   checks;
    int   failures;
    exp_t sb[$];
    exp_t sb_e;
    vec_t vecs[16];

    alu_unit_if bus ();

    alu_unit dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] id, input logic [31:0] exp, input bit accept);
        bus.rs_ready = 1'b1;
        bus.rs_op    = op;
        bus.rs_val1  = a;
        bus.rs_val2  = b;
        bus.rs_id    = id;
        if (accept) sb.push_back('{res: exp, id: id});
    endtask

    task automatic idle();
        bus.rs_ready = 1'b0;
        bus.rs_op    = '0;
        bus.rs_val1  = '0;
        bus.rs_val2  = '0;
        bus.rs_id    = '0;
    endtask

    // Scoreboard: any head that will pop at the next edge must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && !flush && bus.alu_ready && bus.cdb_grant) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: actual res=%h id=%0d required no output",
                         bus.alu_res, bus.alu_id);
            end else begin
                sb_e = sb.pop_front();
                chk("sb_res", bus.alu_res, sb_e.res);
                chk("sb_id", 32'(bus.alu_id), 32'(sb_e.id));
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        vecs[0]  = '{ALU_ADD,  32'h0000_0005, 32'h0000_0007, 32'h0000_000C};
        vecs[1]  = '{ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[2]  = '{ALU_SUB,  32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE};
        vecs[3]  = '{ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
        vecs[4]  = '{ALU_OR,   32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0};
        vecs[5]  = '{ALU_XOR,  32'hAAAA_AAAA, 32'hFFFF_0000, 32'h5555_AAAA};
        vecs[6]  = '{ALU_SHL,  32'h0000_0001, 32'h0000_0023, 32'h0000_0008};
        vecs[7]  = '{ALU_SHR,  32'h8000_0000, 32'h0000_0024, 32'h0800_0000};
        vecs[8]  = '{ALU_SHRA, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000};
        vecs[9]  = '{ALU_EQ,   32'h0000_0007, 32'h0000_0007, 32'h0000_0001};
        vecs[10] = '{ALU_NEQ,  32'h0000_0007, 32'h0000_0007, 32'h0000_0000};
        vecs[11] = '{ALU_LT,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        vecs[12] = '{ALU_LTU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[13] = '{ALU_GE,   32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[14] = '{ALU_GEU,  32'h0000_0005, 32'h0000_0005, 32'h0000_0001};
        vecs[15] = '{4'd14,    32'h0000_0001, 32'h0000_0002, 32'h0000_0000};

        rst = 1'b1;
        flush = 1'b0;
        bus.cdb_grant = 1'b0;
        idle();
        repeat (2) tick();
        chk("rst_ready", 32'(bus.alu_ready), 32'd0);
        chk("rst_busy", 32'(bus.alu_busy), 32'd0);
        chk("rst_res", bus.alu_res, 32'd0);
        chk("rst_id", 32'(bus.alu_id), 32'd0);
        chk("rst_ovf", 32'(bus.alu_overflow), 32'd0);
        rst = 1'b0;
        tick();

        // Single op latency with grant held high
        bus.cdb_grant = 1'b1;
        drive(ALU_ADD, 32'd5, 32'd7, 4'd3, 32'd12, 1'b1);
        tick();
        idle();
        chk("t1_ready", 32'(bus.alu_ready), 32'd1);
        chk("t1_res", bus.alu_res, 32'd12);
        chk("t1_id", 32'(bus.alu_id), 32'd3);
        tick();
        chk("t1_ready_drop", 32'(bus.alu_ready), 32'd0);

        // Opcode table, one issue per cycle
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, 4'(i), vecs[i].exp, 1'b1);
            tick();
        end
        idle();
        repeat (2) tick();
        chk("tbl_drained", 32'(bus.alu_ready), 32'd0);

        // Fill to full, then single-cycle grant
        bus.cdb_grant = 1'b0;
        drive(ALU_ADD, 32'd1, 32'd0, 4'd1, 32'd1, 1'b1);
        tick();
        drive(ALU_ADD, 32'd2, 32'd0, 4'd2, 32'd2, 1'b1);
        tick();
        idle();
        chk("t3_busy_full", 32'(bus.alu_busy), 32'd1);
        chk("t3_head_id1", 32'(bus.alu_id), 32'd1);
        bus.cdb_grant = 1'b1;
        tick();
        bus.cdb_grant = 1'b0;
        chk("t3_busy_drop", 32'(bus.alu_busy), 32'd0);
        chk("t3_ready", 32'(bus.alu_ready), 32'd1);
        chk("t3_head_id2", 32'(bus.alu_id), 32'd2);
        drive(ALU_ADD, 32'd3, 32'd0, 4'd3, 32'd3, 1'b1);
        tick();
        idle();
        chk("t3_refull", 32'(bus.alu_busy), 32'd1);

        // Full queue: push and pop in the same cycle
        drive(ALU_ADD, 32'd4, 32'd0, 4'd4, 32'd4, 1'b1);
        bus.cdb_grant = 1'b1;
        tick();
        idle();
        bus.cdb_grant = 1'b0;
        chk("t4_busy", 32'(bus.alu_busy), 32'd1);
        chk("t4_ovf", 32'(bus.alu_overflow), 32'd0);
        chk("t4_head_id3", 32'(bus.alu_id), 32'd3);

        // Full queue, no pop: issue is dropped
        drive(ALU_ADD, 32'd5, 32'd0, 4'd5, 32'd5, 1'b0);
        tick();
        idle();
        chk("t5_ovf", 32'(bus.alu_overflow), 32'd1);
        chk("t5_head_id3", 32'(bus.alu_id), 32'd3);
        chk("t5_busy", 32'(bus.alu_busy), 32'd1);
        tick();
        chk("t5_ovf_sticky", 32'(bus.alu_overflow), 32'd1);

        // Flush with a concurrent issue
        flush = 1'b1;
        drive(ALU_ADD, 32'd6, 32'd0, 4'd6, 32'd6, 1'b0);
        tick();
        flush = 1'b0;
        idle();
        sb.delete();
        chk("t6_ready", 32'(bus.alu_ready), 32'd0);
        chk("t6_busy", 32'(bus.alu_busy), 32'd0);
        chk("t6_res", bus.alu_res, 32'd0);
        chk("t6_id", 32'(bus.alu_id), 32'd0);
        chk("t6_ovf_kept", 32'(bus.alu_overflow), 32'd1);
        tick();
        chk("t6_issue_gone", 32'(bus.alu_ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_ovf", 32'(bus.alu_overflow), 32'd0);

        // Two more entries, then a bounded drain
        drive(ALU_SUB, 32'd10, 32'd3, 4'd7, 32'd7, 1'b1);
        tick();
        drive(ALU_XOR, 32'h0000_000F, 32'h0000_0003, 4'd8, 32'h0000_000C, 1'b1);
        tick();
        idle();
        bus.cdb_grant = 1'b1;
        for (int n = 0; n < 10 && bus.alu_ready; n++) tick();
        bus.cdb_grant = 1'b0;
        chk("drain_ready", 32'(bus.alu_ready), 32'd0);
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
